// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = ALU, B = memory load)
// and the register-file write port.
//
// Signals:
//   A_valid/A_ready/A_reg/A_data : requester A handshake, 5-bit dest, 32-bit data
//   B_valid/B_ready/B_reg/B_data : requester B handshake, same layout
//   W/W_reg/W_data               : register-file write enable, address, data
//   busy                         : bit r set while a write to register r is pending
//
// Modports:
//   master : requester/register-file side (drives requests, observes the rest)
//   slave  : arbiter side
interface rf_wb_arbiter_if;
   logic        A_valid;
   logic        A_ready;
   logic [4:0]  A_reg;
   logic [31:0] A_data;
   logic        B_valid;
   logic        B_ready;
   logic [4:0]  B_reg;
   logic [31:0] B_data;
   logic        W;
   logic [4:0]  W_reg;
   logic [31:0] W_data;
   logic [31:0] busy;

   modport master (
      output A_valid, A_reg, A_data,
      output B_valid, B_reg, B_data,
      input  A_ready, B_ready,
      input  W, W_reg, W_data, busy
   );

   modport slave (
      input  A_valid, A_reg, A_data,
      input  B_valid, B_reg, B_data,
      output A_ready, B_ready,
      output W, W_reg, W_data, busy
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter. Two requesters each feed a private
// DEPTH-entry FIFO; one head per cycle is granted round-robin, popped and
// registered onto the single register-file write port. A scoreboard of
// pending destination registers is exported on busy.
//
// Ports:
//   CLK  : clock, all state changes on posedge
//   RST  : asynchronous active-high reset
//   bus  : rf_wb_arbiter_if.slave (A/B request handshakes, W port, busy)
//
// Parameters:
//   DEPTH : entries per requester FIFO (power of two, >= 2)
module rf_wb_arbiter #(
   parameter int DEPTH = 2
) (
   input logic          CLK,
   input logic          RST,
   rf_wb_arbiter_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} req_t;

   // FIFO storage carries no reset; occupancy is defined by the counters alone.
   logic [4:0]  a_reg_mem  [DEPTH];
   logic [31:0] a_data_mem [DEPTH];
   logic [4:0]  b_reg_mem  [DEPTH];
   logic [31:0] b_data_mem [DEPTH];

   ptr_t a_wr, a_rd, b_wr, b_rd;
   cnt_t a_cnt, b_cnt;
   req_t last_grant;

   logic a_ready, b_ready;
   logic a_acc, b_acc;
   logic a_ne, b_ne;
   logic gnt_a, gnt_b, gnt_p0;
   logic [4:0]  reg_p0;
   logic [31:0] data_p0;

   logic        vld_p1;
   logic [4:0]  reg_p1;
   logic [31:0] data_p1;
   logic [31:0] busy_v;

   // ---- stage p0: acceptance and grant selection from registered state ----
   // Ready ignores any pop in the same cycle: a full FIFO stays not-ready.
   assign a_ready = (a_cnt != cnt_t'(DEPTH));
   assign b_ready = (b_cnt != cnt_t'(DEPTH));
   assign a_acc   = bus.A_valid && a_ready;
   assign b_acc   = bus.B_valid && b_ready;
   assign a_ne    = (a_cnt != '0);
   assign b_ne    = (b_cnt != '0);

   // On a tie the requester that did not win last time goes next.
   assign gnt_a  = a_ne && (!b_ne || (last_grant == GNT_B));
   assign gnt_b  = b_ne && (!a_ne || (last_grant == GNT_A));
   assign gnt_p0 = gnt_a || gnt_b;

   assign reg_p0  = gnt_a ? a_reg_mem[a_rd]  : b_reg_mem[b_rd];
   assign data_p0 = gnt_a ? a_data_mem[a_rd] : b_data_mem[b_rd];

   always_ff @(posedge CLK) begin
      if (a_acc) begin
         a_reg_mem[a_wr]  <= bus.A_reg;
         a_data_mem[a_wr] <= bus.A_data;
      end
      if (b_acc) begin
         b_reg_mem[b_wr]  <= bus.B_reg;
         b_data_mem[b_wr] <= bus.B_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_wr       <= '0;
         a_rd       <= '0;
         a_cnt      <= '0;
         b_wr       <= '0;
         b_rd       <= '0;
         b_cnt      <= '0;
         last_grant <= GNT_B;
      end else begin
         if (a_acc) a_wr <= a_wr + ptr_t'(1);
         if (gnt_a) a_rd <= a_rd + ptr_t'(1);
         if (b_acc) b_wr <= b_wr + ptr_t'(1);
         if (gnt_b) b_rd <= b_rd + ptr_t'(1);

         case ({a_acc, gnt_a})
            2'b10:   a_cnt <= a_cnt + cnt_t'(1);
            2'b01:   a_cnt <= a_cnt - cnt_t'(1);
            default: a_cnt <= a_cnt;
         endcase
         case ({b_acc, gnt_b})
            2'b10:   b_cnt <= b_cnt + cnt_t'(1);
            2'b01:   b_cnt <= b_cnt - cnt_t'(1);
            default: b_cnt <= b_cnt;
         endcase

         if (gnt_a)      last_grant <= GNT_A;
         else if (gnt_b) last_grant <= GNT_B;
      end
   end

   // ---- stage p1: registered register-file write port ----
   // Writes to r0 are popped like any other entry but never raise W.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_p1  <= 1'b0;
         reg_p1  <= '0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= gnt_p0 && (reg_p0 != 5'd0);
         if (gnt_p0) begin
            reg_p1  <= reg_p0;
            data_p1 <= data_p0;
         end
      end
   end

   // Pending-write scoreboard: every occupied FIFO slot plus the live write.
   always_comb begin
      busy_v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, ptr_t'(ptr_t'(i) - a_rd)} < a_cnt) busy_v[a_reg_mem[i]] = 1'b1;
         if ({1'b0, ptr_t'(ptr_t'(i) - b_rd)} < b_cnt) busy_v[b_reg_mem[i]] = 1'b1;
      end
      if (vld_p1) busy_v[reg_p1] = 1'b1;
      busy_v[0] = 1'b0;
   end

   assign bus.A_ready = a_ready;
   assign bus.B_ready = b_ready;
   assign bus.W       = vld_p1;
   assign bus.W_reg   = reg_p1;
   assign bus.W_data  = data_p1;
   assign bus.busy    = busy_v;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH = 2).
module tb_rf_wb_arbiter;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   rf_wb_arbiter_if bus ();

   rf_wb_arbiter #(.DEPTH(2)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every issued register-file write.
   logic [4:0]  seen_reg  [$];
   logic [31:0] seen_data [$];
   int          seen_cyc  [$];

   always @(negedge CLK) begin
      if (bus.W === 1'b1) begin
         seen_reg.push_back(bus.W_reg);
         seen_data.push_back(bus.W_data);
         seen_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.A_valid = 1'b0;
      bus.A_reg   = '0;
      bus.A_data  = '0;
      bus.B_valid = 1'b0;
      bus.B_reg   = '0;
      bus.B_data  = '0;
   endtask

   task automatic clear_seen();
      seen_reg.delete();
      seen_data.delete();
      seen_cyc.delete();
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      clear_seen();
   endtask

   task automatic send_a(input logic [4:0] r, input logic [31:0] d);
      int n;
      bus.A_valid = 1'b1;
      bus.A_reg   = r;
      bus.A_data  = d;
      n = 0;
      while (bus.A_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_a_timeout: reg %0d never accepted, A_ready=%b required 1", r, bus.A_ready);
      end else begin
         step();
      end
      bus.A_valid = 1'b0;
   endtask

   task automatic send_b(input logic [4:0] r, input logic [31:0] d);
      int n;
      bus.B_valid = 1'b1;
      bus.B_reg   = r;
      bus.B_data  = d;
      n = 0;
      while (bus.B_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_b_timeout: reg %0d never accepted, B_ready=%b required 1", r, bus.B_ready);
      end else begin
         step();
      end
      bus.B_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1'b1;
      #3;
      checks++; if (bus.W !== 1'b0) begin errors++; $display("FAIL reset_W: got %b want 0", bus.W); end
      checks++; if (bus.W_reg !== 5'd0) begin errors++; $display("FAIL reset_W_reg: got %0d want 0", bus.W_reg); end
      checks++; if (bus.W_data !== 32'h0) begin errors++; $display("FAIL reset_W_data: got %h want 0", bus.W_data); end
      checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
      checks++; if ({bus.A_ready, bus.B_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b want 11", {bus.A_ready, bus.B_ready}); end
      step();
      step();
      RST = 1'b0;
      step();
      checks++; if ({bus.A_ready, bus.B_ready} !== 2'b11) begin errors++; $display("FAIL post_reset_ready: got %b want 11", {bus.A_ready, bus.B_ready}); end
      checks++; if (bus.W !== 1'b0) begin errors++; $display("FAIL post_reset_W: got %b want 0", bus.W); end
   endtask

   task automatic test_single_write();
      do_reset();
      bus.A_valid = 1'b1;
      bus.A_reg   = 5'd5;
      bus.A_data  = 32'hDEADBEEF;
      checks++; if (bus.A_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.A_ready); end
      step();                                   // edge 1: accepted
      bus.A_valid = 1'b0;
      checks++; if (bus.busy[5] !== 1'b1) begin errors++; $display("FAIL single_busy_e1: got %b want 1", bus.busy[5]); end
      checks++; if (bus.W !== 1'b0) begin errors++; $display("FAIL single_W_e1: got %b want 0", bus.W); end
      step();                                   // edge 2: issued
      checks++; if (bus.W !== 1'b1) begin errors++; $display("FAIL single_W_e2: got %b want 1", bus.W); end
      checks++; if (bus.W_reg !== 5'd5) begin errors++; $display("FAIL single_W_reg_e2: got %0d want 5", bus.W_reg); end
      checks++; if (bus.W_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_W_data_e2: got %h want deadbeef", bus.W_data); end
      checks++; if (bus.busy !== 32'h0000_0020) begin errors++; $display("FAIL single_busy_e2: got %h want 00000020", bus.busy); end
      step();                                   // edge 3: drained
      checks++; if (bus.W !== 1'b0) begin errors++; $display("FAIL single_W_e3: got %b want 0", bus.W); end
      checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL single_busy_e3: got %h want 0", bus.busy); end
      checks++; if (bus.W_reg !== 5'd5) begin errors++; $display("FAIL single_W_reg_hold: got %0d want 5", bus.W_reg); end
   endtask

   task automatic test_round_robin();
      logic [4:0] exp_reg [6];
      exp_reg = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
      do_reset();
      fork
         begin
            send_a(5'd1, 32'hA000_0001);
            send_a(5'd2, 32'hA000_0002);
            send_a(5'd3, 32'hA000_0003);
         end
         begin
            send_b(5'd11, 32'hB000_000B);
            send_b(5'd12, 32'hB000_000C);
            send_b(5'd13, 32'hB000_000D);
         end
      join
      repeat (6) step();
      checks++;
      if (seen_reg.size() != 6) begin
         errors++;
         $display("FAIL rr_count: got %0d writes want 6", seen_reg.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_data;
            exp_data = (exp_reg[i] > 5'd10) ? (32'hB000_0000 | 32'(exp_reg[i])) : (32'hA000_0000 | 32'(exp_reg[i]));
            checks++; if (seen_reg[i] !== exp_reg[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, seen_reg[i], exp_reg[i]); end
            checks++; if (seen_data[i] !== exp_data) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, seen_data[i], exp_data); end
            checks++; if (seen_cyc[i] != seen_cyc[0] + i) begin errors++; $display("FAIL rr_spacing[%0d]: got cycle %0d want %0d", i, seen_cyc[i], seen_cyc[0] + i); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.A_valid = 1'b1; bus.A_reg = 5'd7;  bus.A_data = 32'h7;
      bus.B_valid = 1'b1; bus.B_reg = 5'd21; bus.B_data = 32'h21;
      step();                                   // edge 1: A7, B21 in
      bus.A_reg = 5'd8;  bus.A_data = 32'h8;
      bus.B_reg = 5'd22; bus.B_data = 32'h22;
      checks++; if (bus.B_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_e1: got %b want 1", bus.B_ready); end
      step();                                   // edge 2: A8, B22 in; A7 issued
      bus.A_valid = 1'b0;
      bus.B_reg = 5'd23; bus.B_data = 32'h23;
      checks++; if (bus.B_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus.B_ready); end
      checks++; if (bus.W_reg !== 5'd7 || bus.W !== 1'b1) begin errors++; $display("FAIL bp_w_e2: got W=%b reg %0d want W=1 reg 7", bus.W, bus.W_reg); end
      checks++; if (bus.busy !== ((32'h1 << 7) | (32'h1 << 8) | (32'h1 << 21) | (32'h1 << 22))) begin errors++; $display("FAIL bp_busy_e2: got %h want 00600180", bus.busy); end
      step();                                   // edge 3: B23 stalled, B21 popped
      checks++; if (bus.W_reg !== 5'd21 || bus.W !== 1'b1) begin errors++; $display("FAIL bp_w_e3: got W=%b reg %0d want W=1 reg 21", bus.W, bus.W_reg); end
      checks++; if (bus.B_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.B_ready); end
      step();                                   // edge 4: B23 accepted
      bus.B_valid = 1'b0;
      checks++; if (bus.W_reg !== 5'd8 || bus.W !== 1'b1) begin errors++; $display("FAIL bp_w_e4: got W=%b reg %0d want W=1 reg 8", bus.W, bus.W_reg); end
      step();
      checks++; if (bus.W_reg !== 5'd22 || bus.W !== 1'b1) begin errors++; $display("FAIL bp_w_e5: got W=%b reg %0d want W=1 reg 22", bus.W, bus.W_reg); end
      step();
      checks++; if (bus.W_reg !== 5'd23 || bus.W_data !== 32'h23 || bus.W !== 1'b1) begin errors++; $display("FAIL bp_w_e6: got W=%b reg %0d data %h want W=1 reg 23 data 23", bus.W, bus.W_reg, bus.W_data); end
      step();
      checks++; if (bus.W !== 1'b0 || bus.busy !== 32'h0) begin errors++; $display("FAIL bp_idle: got W=%b busy %h want W=0 busy 0", bus.W, bus.busy); end
   endtask

   task automatic test_reg_zero();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_a(5'd0, 32'h1234);
         checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL r0_busy[%0d]: got %h want 0", i, bus.busy); end
      end
      repeat (3) step();
      checks++; if (seen_reg.size() != 0) begin errors++; $display("FAIL r0_no_write: got %0d writes want 0", seen_reg.size()); end
      send_a(5'd9, 32'h9999);
      step();
      checks++; if (bus.W !== 1'b1 || bus.W_reg !== 5'd9 || bus.W_data !== 32'h9999) begin errors++; $display("FAIL r0_followup: got W=%b reg %0d data %h want W=1 reg 9 data 9999", bus.W, bus.W_reg, bus.W_data); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.A_valid = 1'b1; bus.A_reg = 5'd3; bus.A_data = 32'h3333;
      bus.B_valid = 1'b1; bus.B_reg = 5'd4; bus.B_data = 32'h4444;
      repeat (4) step();
      checks++; if (bus.busy !== 32'h0000_0018) begin errors++; $display("FAIL rm_busy_before: got %h want 00000018", bus.busy); end
      checks++; if (bus.W !== 1'b1) begin errors++; $display("FAIL rm_W_before: got %b want 1", bus.W); end
      #2;
      RST = 1'b1;
      #1;
      idle_inputs();
      checks++; if (bus.W !== 1'b0 || bus.W_reg !== 5'd0 || bus.W_data !== 32'h0) begin errors++; $display("FAIL rm_outputs: got W=%b reg %0d data %h want all 0", bus.W, bus.W_reg, bus.W_data); end
      checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL rm_busy: got %h want 0", bus.busy); end
      checks++; if ({bus.A_ready, bus.B_ready} !== 2'b11) begin errors++; $display("FAIL rm_ready: got %b want 11", {bus.A_ready, bus.B_ready}); end
      #2;
      RST = 1'b0;
      clear_seen();
      repeat (5) step();
      checks++; if (seen_reg.size() != 0) begin errors++; $display("FAIL rm_no_w_after: got %0d writes want 0", seen_reg.size()); end
      checks++; if ({bus.A_ready, bus.B_ready} !== 2'b11) begin errors++; $display("FAIL rm_ready_after: got %b want 11", {bus.A_ready, bus.B_ready}); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 5; i++) send_a(5'(i + 16), 32'hC0DE_0000 | 32'(i));
      repeat (3) step();
      checks++;
      if (seen_reg.size() != 5) begin
         errors++;
         $display("FAIL b2b_count: got %0d writes want 5", seen_reg.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen_reg[i] !== 5'(i + 17) || seen_data[i] !== (32'hC0DE_0000 | 32'(i + 1))) begin
               errors++;
               $display("FAIL b2b[%0d]: got reg %0d data %h want reg %0d data %h", i, seen_reg[i], seen_data[i], i + 17, 32'hC0DE_0000 | 32'(i + 1));
            end
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_write();
      test_round_robin();
      test_backpressure();
      test_reg_zero();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, default 2, entries per requester queue (power of two, >=2).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: A_valid  input  1  requester A (ALU writeback) offers a write.
REQ-005 SHALL have port: A_ready  output  1  queue A can accept this cycle.
REQ-006 SHALL have port: A_reg  input  5  requester A destination register.
REQ-007 SHALL have port: A_data  input  32  requester A write data.
REQ-008 SHALL have ports B_valid, B_ready, B_reg, B_data: directions and widths as for A; requester B is memory-load writeback.
REQ-009 SHALL have port: W  output  1  register-file write enable.
REQ-010 SHALL have port: W_reg  output  5  register-file write address.
REQ-011 SHALL have port: W_data  output  32  register-file write data.
REQ-012 SHALL have port: busy  output  32  bit r set = write to register r pending.

Function
REQ-013 SHALL give each requester a private FIFO of DEPTH entries {reg[4:0], data[31:0]}.
REQ-014 SHALL accept a request at a posedge when X_valid and X_ready are both 1; accepted entry is written to the tail of FIFO X.
REQ-015 SHALL drive X_ready = (FIFO X count < DEPTH), combinational from registered state only; no same-cycle dequeue credit (full FIFO -> ready 0 even while draining).
REQ-016 SHALL perform at most one grant per cycle, selected combinationally from the FIFO heads.
REQ-017 SHALL grant the only non-empty FIFO when exactly one is non-empty; no grant when both are empty.
REQ-018 SHALL, when both FIFOs are non-empty, grant the requester not recorded in last_grant (round-robin).
REQ-019 SHALL update last_grant to the granted requester on every grant; hold it otherwise.
REQ-020 SHALL pop the granted head and register it: W, W_reg, W_data valid the cycle after the grant.
REQ-021 SHALL force W=0 with no grant; W_reg/W_data hold their previous values.
REQ-022 SHALL accept and pop entries with reg=0 normally but issue them with W=0 (writes to register 0 discarded).
REQ-023 SHALL preserve per-requester order; no ordering guarantee between A and B beyond round-robin.
REQ-024 SHALL have latency: accept at edge N -> W asserted after edge N+1 at earliest, if uncontended.
REQ-025 SHALL support simultaneous enqueue and dequeue on one FIFO in the same cycle; count is unchanged.
REQ-026 SHALL compute FIFO pointers modulo DEPTH (wrap-around); count range 0..DEPTH.
REQ-027 SHALL set busy[r] when any valid FIFO entry in A or B, or the output register with W=1, targets r (r!=0).
REQ-028 SHALL hold busy[0]=0 always.
REQ-029 SHALL clear busy[r] the cycle after the last pending write to r leaves the output register.

Reset
REQ-030 SHALL, while RST=1 (asynchronous to CLK), empty both FIFOs and drive W=0, W_reg=0, W_data=0, busy=0, and last_grant=B; A wins the first tie.
REQ-031 SHALL drive A_ready=B_ready=1 during and immediately after reset.
REQ-032 SHALL discard all queued and in-flight writes on reset assertion mid-operation; none issued after release.

Verification
REQ-033 SHALL be verified by: Single A write (reg 5, 0xDEADBEEF) accepted at edge 1 -> W=1, W_reg=5, W_data=0xDEADBEEF after edge 2; busy[5]=1 after edge 1, 0 after edge 3.
REQ-034 SHALL be verified by: A and B both valid every cycle from reset (A regs 1,2,3; B regs 11,12,13) -> issue order 1,11,2,12,3,13, one W per cycle.
REQ-035 SHALL be verified by: B valid, W never drained (A flood first), DEPTH=2 -> B_ready drops to 0 after 2 accepts, third B request stalls until a B pop.
REQ-036 SHALL be verified by: A write to reg 0 data 0x1234 -> entry consumed, W stays 0, busy stays 0.
REQ-037 SHALL be verified by: RST pulsed between edges while both FIFOs full -> outputs zero immediately, no W pulse afterwards, A_ready=B_ready=1.
REQ-038 SHALL be verified by: 5 A writes back-to-back, A only -> pointer wrap exercised; W_reg sequence equals input order, no drops.
